// File: rtl/reg_scoreboard_if.sv
// ---------------------------------------------------------------------------
// reg_scoreboard_if
//   Bundles the decode-side issue/source signals, the writeback and squash
//   retire signals, and the scoreboard status outputs into one interface.
//   master modport: the pipeline (drives issue/retire, observes stall/status)
//   slave  modport: the scoreboard itself
//
//   issue_valid, issue_regwrite, issue_rd   instruction presented at decode
//   rs1_used, rs1, rs2_used, rs2            source registers read by it
//   wb_valid, wb_rd                         write retired at writeback
//   squash_valid, squash_rd                 pending write cancelled by flush
//   stall_o, issue_ack_o                    combinational issue decision
//   busy_mask_o, err_o                      registered status
// ---------------------------------------------------------------------------
interface reg_scoreboard_if #(
    parameter int NREG = 32,
    parameter int AW   = 5
);
    logic            issue_valid;
    logic            issue_regwrite;
    logic [AW-1:0]   issue_rd;
    logic            rs1_used;
    logic [AW-1:0]   rs1;
    logic            rs2_used;
    logic [AW-1:0]   rs2;
    logic            wb_valid;
    logic [AW-1:0]   wb_rd;
    logic            squash_valid;
    logic [AW-1:0]   squash_rd;
    logic            stall_o;
    logic            issue_ack_o;
    logic [NREG-1:0] busy_mask_o;
    logic            err_o;

    modport master (
        output issue_valid, issue_regwrite, issue_rd,
        output rs1_used, rs1, rs2_used, rs2,
        output wb_valid, wb_rd, squash_valid, squash_rd,
        input  stall_o, issue_ack_o, busy_mask_o, err_o
    );

    modport slave (
        input  issue_valid, issue_regwrite, issue_rd,
        input  rs1_used, rs1, rs2_used, rs2,
        input  wb_valid, wb_rd, squash_valid, squash_rd,
        output stall_o, issue_ack_o, busy_mask_o, err_o
    );
endinterface

// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
//   Register scoreboard beside the decoder. Each architectural register has
//   an in-flight write counter: incremented by an accepted issue that writes
//   it, decremented by writeback retire and by squash. Decode stalls while a
//   used source register has pending writes, or while the destination
//   counter is saturated. x0 is never tracked.
//
//   Ports:
//     clk     rising-edge clock
//     rst_n   synchronous active-low reset (clears all counters and err_o)
//     sb      reg_scoreboard_if.slave: issue/source/retire inputs,
//             stall_o / issue_ack_o (combinational), busy_mask_o / err_o
//             (registered; err_o sticky until reset)
//
//   Configuration macro: SB_BYPASS_EN
//     defined   -> a source hazard is suppressed when writeback retires the
//                  last pending write of that register this cycle (and no
//                  squash hits it), since WB forwards the value to decode.
//     undefined -> the hazard holds through the retire cycle.
// ---------------------------------------------------------------------------
module reg_scoreboard #(
    parameter int NREG  = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    reg_scoreboard_if.slave sb
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic [NREG-1:0]  busy_q, busy_d;
    logic             err_q, err_d;

    logic [NREG-1:0]  fwd;      // source hazard on r hidden by WB forwarding
    logic             hazard;
    logic             full;
    logic             stall;
    logic             ack;

    // ------------------------------------------------------------------
    // Issue decision: purely combinational from current counts and inputs.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any conditional logic so
        // no path leaves it unassigned (which would infer a latch).
        fwd = '0;
`ifdef SB_BYPASS_EN
        for (int r = 1; r < NREG; r++) begin
            fwd[r] = sb.wb_valid && (sb.wb_rd == AW'(r)) && (cnt_q[r] == CNT_ONE) &&
                     !(sb.squash_valid && (sb.squash_rd == AW'(r)));
        end
`endif
        hazard = (sb.rs1_used && (sb.rs1 != '0) && (cnt_q[sb.rs1] != '0) && !fwd[sb.rs1]) ||
                 (sb.rs2_used && (sb.rs2 != '0) && (cnt_q[sb.rs2] != '0) && !fwd[sb.rs2]);
        // Forwarding never relieves a saturated destination counter.
        full   = sb.issue_regwrite && (sb.issue_rd != '0) && (cnt_q[sb.issue_rd] == CNT_MAX);
        stall  = sb.issue_valid && (hazard || full);
        ack    = sb.issue_valid && !stall;
    end

    // ------------------------------------------------------------------
    // Counter update: cnt + inc - dec evaluated one bit wider so underflow
    // is detected rather than wrapped; an underflow clamps to 0 and sets err.
    // ------------------------------------------------------------------
    always_comb begin
        logic             inc;
        logic [1:0]       dec;
        logic [CNT_W:0]   sum;
        logic [CNT_W:0]   diff;
        inc    = 1'b0;
        dec    = '0;
        sum    = '0;
        diff   = '0;
        cnt_d  = cnt_q;
        busy_d = '0;
        err_d  = err_q;
        for (int r = 1; r < NREG; r++) begin
            inc  = ack && sb.issue_regwrite && (sb.issue_rd == AW'(r));
            dec  = {1'b0, sb.wb_valid && (sb.wb_rd == AW'(r))} +
                   {1'b0, sb.squash_valid && (sb.squash_rd == AW'(r))};
            sum  = {1'b0, cnt_q[r]} + (CNT_W+1)'(inc);
            diff = sum - (CNT_W+1)'(dec);
            if (sum < (CNT_W+1)'(dec)) begin
                cnt_d[r] = '0;
                err_d    = 1'b1;
            end else begin
                cnt_d[r] = diff[CNT_W-1:0];
            end
            busy_d[r] = (cnt_d[r] != '0);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (!rst_n) begin
            // NOTE: the counter array is reset explicitly: a mid-run reset
            // must discard all pending writes, so it cannot be left to
            // power-up contents like a plain data memory.
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign sb.stall_o     = stall;
    assign sb.issue_ack_o = ack;
    assign sb.busy_mask_o = busy_q;
    assign sb.err_o       = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_reg_scoreboard
//   Self-checking bench for reg_scoreboard. A behavioural model holds an
//   integer pending-write count per register and a sticky error flag,
//   advanced once per clock edge from the stimulus the bench drives.
//   Inputs change 1 ns after the rising edge; outputs are compared 1 ns
//   later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_reg_scoreboard;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int MAXC = 3;   // 2^CNT_W - 1 with CNT_W = 2

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    reg_scoreboard_if #(.NREG(NREG), .AW(AW)) sb ();

    reg_scoreboard #(.NREG(NREG), .AW(AW), .CNT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    int m_cnt [NREG];
    bit m_err;

    function automatic bit m_fwd(int s);
`ifdef SB_BYPASS_EN
        return sb.wb_valid && int'(sb.wb_rd) == s && m_cnt[s] == 1 &&
               !(sb.squash_valid && int'(sb.squash_rd) == s);
`else
        return 1'b0 & s[0];
`endif
    endfunction

    function automatic bit m_stall();
        bit haz, full;
        int s1, s2, rd;
        s1 = int'(sb.rs1); s2 = int'(sb.rs2); rd = int'(sb.issue_rd);
        haz  = (sb.rs1_used && s1 != 0 && m_cnt[s1] > 0 && !m_fwd(s1)) ||
               (sb.rs2_used && s2 != 0 && m_cnt[s2] > 0 && !m_fwd(s2));
        full = sb.issue_regwrite && rd != 0 && m_cnt[rd] == MAXC;
        return sb.issue_valid && (haz || full);
    endfunction

    function automatic logic [NREG-1:0] m_busy();
        logic [NREG-1:0] b;
        for (int r = 0; r < NREG; r++) b[r] = (m_cnt[r] != 0);
        return b;
    endfunction

    // Advance the clock one edge and apply the same edge to the model.
    task automatic tick();
        bit ack;
        int add, sub;
        ack = sb.issue_valid && !m_stall();
        @(posedge clk);
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
            m_err = 1'b0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                add = (ack && sb.issue_regwrite && int'(sb.issue_rd) == r) ? 1 : 0;
                sub = ((sb.wb_valid && int'(sb.wb_rd) == r) ? 1 : 0) +
                      ((sb.squash_valid && int'(sb.squash_rd) == r) ? 1 : 0);
                if (m_cnt[r] + add < sub) begin
                    m_cnt[r] = 0;
                    m_err    = 1'b1;
                end else begin
                    m_cnt[r] = m_cnt[r] + add - sub;
                end
            end
        end
        #1;
    endtask

    task automatic set_idle();
        sb.issue_valid = 0; sb.issue_regwrite = 0; sb.issue_rd = '0;
        sb.rs1_used = 0; sb.rs1 = '0; sb.rs2_used = 0; sb.rs2 = '0;
        sb.wb_valid = 0; sb.wb_rd = '0; sb.squash_valid = 0; sb.squash_rd = '0;
    endtask

    task automatic issue_wr(int rd);
        set_idle();
        sb.issue_valid = 1; sb.issue_regwrite = 1; sb.issue_rd = AW'(rd);
    endtask

    task automatic retire(int rd);
        set_idle();
        sb.wb_valid = 1; sb.wb_rd = AW'(rd);
    endtask

    // ---------------- directed tests ----------------
    task automatic test_reset();
        set_idle();
        rst_n = 0;
        tick();
        rst_n = 1;
        #1;
        n_checks++;
        if (sb.busy_mask_o !== '0) begin n_fail++; $display("FAIL reset_busy: got %h expected 0", sb.busy_mask_o); end
        n_checks++;
        if (sb.stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", sb.stall_o); end
        n_checks++;
        if (sb.err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", sb.err_o); end
        tick();
    endtask

    task automatic test_raw_hazard();
        bit exp_wb_stall;
`ifdef SB_BYPASS_EN
        exp_wb_stall = 1'b0;
`else
        exp_wb_stall = 1'b1;
`endif
        issue_wr(5);
        #1;
        n_checks++;
        if (sb.issue_ack_o !== 1'b1) begin n_fail++; $display("FAIL raw_issue_ack: got %b expected 1", sb.issue_ack_o); end
        tick();
        set_idle();
        sb.issue_valid = 1; sb.rs1_used = 1; sb.rs1 = AW'(5);
        #1;
        n_checks++;
        if (sb.stall_o !== 1'b1) begin n_fail++; $display("FAIL raw_stall_n1: got %b expected 1", sb.stall_o); end
        n_checks++;
        if (sb.busy_mask_o[5] !== 1'b1) begin n_fail++; $display("FAIL raw_busy5: got %b expected 1", sb.busy_mask_o[5]); end
        tick();
        #1;
        n_checks++;
        if (sb.stall_o !== 1'b1) begin n_fail++; $display("FAIL raw_stall_hold: got %b expected 1", sb.stall_o); end
        sb.wb_valid = 1; sb.wb_rd = AW'(5);
        #1;
        n_checks++;
        if (sb.stall_o !== exp_wb_stall) begin n_fail++; $display("FAIL raw_stall_wb_cycle: got %b expected %b", sb.stall_o, exp_wb_stall); end
        tick();
        sb.wb_valid = 0;
        #1;
        n_checks++;
        if (sb.stall_o !== 1'b0 || sb.issue_ack_o !== 1'b1) begin
            n_fail++; $display("FAIL raw_after_wb: got stall=%b ack=%b expected stall=0 ack=1", sb.stall_o, sb.issue_ack_o);
        end
        tick();
        set_idle();
        tick();
    endtask

    task automatic test_full();
        for (int k = 0; k < 3; k++) begin
            issue_wr(7);
            #1;
            n_checks++;
            if (sb.issue_ack_o !== 1'b1) begin n_fail++; $display("FAIL full_issue%0d_ack: got %b expected 1", k, sb.issue_ack_o); end
            tick();
        end
        issue_wr(7);
        #1;
        n_checks++;
        if (sb.stall_o !== 1'b1 || sb.issue_ack_o !== 1'b0) begin
            n_fail++; $display("FAIL full_4th: got stall=%b ack=%b expected stall=1 ack=0", sb.stall_o, sb.issue_ack_o);
        end
        tick();
        sb.wb_valid = 1; sb.wb_rd = AW'(7);
        #1;
        n_checks++;
        if (sb.stall_o !== 1'b1) begin n_fail++; $display("FAIL full_wb_cycle_stall: got %b expected 1", sb.stall_o); end
        tick();
        sb.wb_valid = 0;
        #1;
        n_checks++;
        if (sb.issue_ack_o !== 1'b1) begin n_fail++; $display("FAIL full_4th_after_wb: got %b expected 1", sb.issue_ack_o); end
        tick();
        for (int k = 0; k < 3; k++) begin retire(7); tick(); end
        set_idle();
        #1;
        n_checks++;
        if (sb.busy_mask_o[7] !== 1'b0 || sb.err_o !== 1'b0) begin
            n_fail++; $display("FAIL full_drain: got busy7=%b err=%b expected 0 0", sb.busy_mask_o[7], sb.err_o);
        end
    endtask

    task automatic test_same_cycle_net();
        issue_wr(9);
        tick();
        issue_wr(9);
        sb.wb_valid = 1; sb.wb_rd = AW'(9);
        #1;
        n_checks++;
        if (sb.issue_ack_o !== 1'b1) begin n_fail++; $display("FAIL net_ack: got %b expected 1", sb.issue_ack_o); end
        tick();
        set_idle();
        #1;
        n_checks++;
        if (sb.busy_mask_o[9] !== 1'b1) begin n_fail++; $display("FAIL net_busy9: got %b expected 1", sb.busy_mask_o[9]); end
        retire(9);
        tick();
        set_idle();
        #1;
        n_checks++;
        if (sb.busy_mask_o[9] !== 1'b0 || sb.err_o !== 1'b0) begin
            n_fail++; $display("FAIL net_cnt_was_1: got busy9=%b err=%b expected 0 0", sb.busy_mask_o[9], sb.err_o);
        end
    endtask

    task automatic test_underflow();
        issue_wr(3);
        tick();
        retire(3);
        sb.squash_valid = 1; sb.squash_rd = AW'(3);
        tick();
        set_idle();
        #1;
        n_checks++;
        if (sb.busy_mask_o[3] !== 1'b0 || sb.err_o !== 1'b1) begin
            n_fail++; $display("FAIL underflow: got busy3=%b err=%b expected 0 1", sb.busy_mask_o[3], sb.err_o);
        end
        for (int k = 0; k < 4; k++) tick();
        n_checks++;
        if (sb.err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", sb.err_o); end
        // Counters keep working after an error.
        issue_wr(3);
        tick();
        set_idle();
        #1;
        n_checks++;
        if (sb.busy_mask_o[3] !== 1'b1) begin n_fail++; $display("FAIL post_err_issue: got %b expected 1", sb.busy_mask_o[3]); end
    endtask

    task automatic test_x0_and_reset();
        set_idle();
        rst_n = 0;
        tick();
        rst_n = 1;
        set_idle();
        sb.issue_valid = 1; sb.issue_regwrite = 1; sb.issue_rd = '0;
        sb.rs1_used = 1; sb.rs1 = '0;
        sb.wb_valid = 1; sb.wb_rd = '0;
        sb.squash_valid = 1; sb.squash_rd = '0;
        #1;
        n_checks++;
        if (sb.stall_o !== 1'b0 || sb.issue_ack_o !== 1'b1) begin
            n_fail++; $display("FAIL x0_issue: got stall=%b ack=%b expected 0 1", sb.stall_o, sb.issue_ack_o);
        end
        tick();
        set_idle();
        #1;
        n_checks++;
        if (sb.busy_mask_o !== '0 || sb.err_o !== 1'b0) begin
            n_fail++; $display("FAIL x0_state: got busy=%h err=%b expected 0 0", sb.busy_mask_o, sb.err_o);
        end
        issue_wr(4); tick();
        issue_wr(4); tick();
        set_idle();
        #1;
        n_checks++;
        if (sb.busy_mask_o !== 32'h0000_0010) begin n_fail++; $display("FAIL pre_reset_busy: got %h expected 00000010", sb.busy_mask_o); end
        // A retire on reg 4 during the reset edge must not be counted.
        retire(4);
        rst_n = 0;
        tick();
        rst_n = 1;
        set_idle();
        #1;
        n_checks++;
        if (sb.busy_mask_o !== '0 || sb.err_o !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: got busy=%h err=%b expected 0 0", sb.busy_mask_o, sb.err_o);
        end
        retire(4);
        tick();
        set_idle();
        #1;
        n_checks++;
        if (sb.err_o !== 1'b1) begin n_fail++; $display("FAIL counters_zero_after_reset: got err=%b expected 1", sb.err_o); end
    endtask

    // ---------------- randomized test against the model ----------------
    task automatic test_random();
        int r;
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 249) != 0);
            sb.issue_valid    = ($urandom_range(0, 3) != 0);
            sb.issue_regwrite = ($urandom_range(0, 4) != 0);
            sb.issue_rd       = AW'($urandom_range(0, 7));
            sb.rs1_used       = $urandom_range(0, 1);
            sb.rs1            = AW'($urandom_range(0, 7));
            sb.rs2_used       = $urandom_range(0, 1);
            sb.rs2            = AW'($urandom_range(0, 7));
            r = $urandom_range(0, 7);
            sb.wb_valid = (m_cnt[r] > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 39) == 0);
            sb.wb_rd    = AW'(r);
            r = $urandom_range(0, 7);
            sb.squash_valid = (m_cnt[r] > 0) && ($urandom_range(0, 7) == 0);
            sb.squash_rd    = AW'(r);
            #1;
            n_checks++;
            if (sb.stall_o !== m_stall() || sb.issue_ack_o !== (sb.issue_valid && !m_stall())) begin
                n_fail++;
                $display("FAIL rand_issue cyc %0d: got stall=%b ack=%b expected stall=%b ack=%b",
                         i, sb.stall_o, sb.issue_ack_o, m_stall(), sb.issue_valid && !m_stall());
            end
            n_checks++;
            if (sb.busy_mask_o !== m_busy() || sb.err_o !== m_err) begin
                n_fail++;
                $display("FAIL rand_state cyc %0d: got busy=%h err=%b expected busy=%h err=%b",
                         i, sb.busy_mask_o, sb.err_o, m_busy(), m_err);
            end
            tick();
        end
        rst_n = 1;
        set_idle();
    endtask

    initial begin
        rst_n = 1;
        m_err = 1'b0;
        for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
        set_idle();
        test_reset();
        test_raw_hazard();
        test_full();
        test_same_cycle_net();
        test_underflow();
        test_x0_and_reset();
        rst_n = 0; tick(); rst_n = 1;
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
